// File: rtl/hdc_ctrl_pkg.sv
// Shared types for the HDC controller blocks: sequencer state encoding and
// the handshake flags decoded from it.
package hdc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } fold_state_e;

    typedef struct packed {
        logic fin_ready;
        logic fold_valid;
        logic busy;
    } seq_flags_t;

    // Handshake flags are a pure function of the sequencer state.
    function automatic seq_flags_t decode_flags(input fold_state_e st);
        seq_flags_t f;
        case (st)
            IDLE:    f = '{fin_ready: 1'b1, fold_valid: 1'b0, busy: 1'b0};
            ISSUE:   f = '{fin_ready: 1'b0, fold_valid: 1'b1, busy: 1'b1};
            WAIT:    f = '{fin_ready: 1'b0, fold_valid: 1'b0, busy: 1'b1};
            default: f = '{fin_ready: 1'b1, fold_valid: 1'b0, busy: 1'b0};
        endcase
        return f;
    endfunction

endpackage

// File: rtl/fold_sequencer.sv
// Steps a frame through NUM_FOLDS fold beats, waits for the fused result,
// counts completed frames and flags stray result pulses.
module fold_sequencer
    import hdc_ctrl_pkg::*;
#(
    parameter int NUM_FOLDS       = 1,
    parameter int NUM_FOLDS_WIDTH = 1,
    parameter int FRAME_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fin_valid,
    output logic                       fin_ready,
    output logic                       fold_valid,
    input  logic                       fold_ready,
    output logic [NUM_FOLDS_WIDTH-1:0] fold_counter,
    output logic                       done,
    input  logic                       res_valid,
    output logic                       busy,
    output logic [FRAME_CNT_WIDTH-1:0] frame_count,
    output logic                       err
);

    localparam logic [NUM_FOLDS_WIDTH-1:0] LAST_IDX = NUM_FOLDS_WIDTH'(NUM_FOLDS - 1);

    fold_state_e                 state_q, state_d;
    logic [NUM_FOLDS_WIDTH-1:0]  idx_q, idx_d;
    logic [FRAME_CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
    logic                        err_q, err_d;
    seq_flags_t                  flags_q, flags_d;
    logic [NUM_FOLDS_WIDTH-1:0]  fold_counter_q, fold_counter_d;
    logic                        done_q, done_d;

    // Next-state, index, frame counter and error flag; outputs are
    // precomputed from the next state so every output leaves a flop.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        frame_cnt_d = frame_cnt_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (fin_valid) begin
                    state_d = ISSUE;
                    idx_d   = '0;
                end else begin
                    state_d = IDLE;
                end
                if (res_valid) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
            end
            ISSUE: begin
                if (fold_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = WAIT;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + NUM_FOLDS_WIDTH'(1'b1);
                    end
                end else begin
                    idx_d = idx_q;
                end
                if (res_valid) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
            end
            WAIT: begin
                // A frame still offered here is taken in the following IDLE cycle.
                if (res_valid) begin
                    state_d     = IDLE;
                    frame_cnt_d = frame_cnt_q + FRAME_CNT_WIDTH'(1'b1);
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase

        flags_d        = decode_flags(state_d);
        done_d         = (state_d == ISSUE) && (idx_d == LAST_IDX);
        fold_counter_d = (state_d == ISSUE) ? idx_d : '0;
    end

    // Single state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            frame_cnt_q    <= '0;
            err_q          <= 1'b0;
            flags_q        <= decode_flags(IDLE);
            fold_counter_q <= '0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            frame_cnt_q    <= frame_cnt_d;
            err_q          <= err_d;
            flags_q        <= flags_d;
            fold_counter_q <= fold_counter_d;
            done_q         <= done_d;
        end
    end

    assign fin_ready    = flags_q.fin_ready;
    assign fold_valid   = flags_q.fold_valid;
    assign busy         = flags_q.busy;
    assign fold_counter = fold_counter_q;
    assign done         = done_q;
    assign frame_count  = frame_cnt_q;
    assign err          = err_q;

endmodule

// File: tb/tb_fold_sequencer.sv
// Scoreboard bench: a 4-fold instance with a 2-bit frame counter and an
// unfolded instance, directed frames with hand-computed beats.
module tb_fold_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       a_fin_valid, a_fin_ready, a_fold_valid, a_fold_ready;
    logic       a_done, a_res_valid, a_busy, a_err;
    logic [1:0] a_fold_counter, a_frame_count;
    logic       b_fin_valid, b_fin_ready, b_fold_valid, b_fold_ready;
    logic       b_done, b_res_valid, b_busy, b_err;
    logic [0:0] b_fold_counter;
    logic [15:0] b_frame_count;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0] cnt;
        logic       done;
    } beat_t;

    beat_t qa[$];
    beat_t qb[$];

    fold_sequencer #(.NUM_FOLDS(4), .NUM_FOLDS_WIDTH(2), .FRAME_CNT_WIDTH(2)) dut_a (
        .clk(clk), .rst(rst),
        .fin_valid(a_fin_valid), .fin_ready(a_fin_ready),
        .fold_valid(a_fold_valid), .fold_ready(a_fold_ready),
        .fold_counter(a_fold_counter), .done(a_done),
        .res_valid(a_res_valid), .busy(a_busy),
        .frame_count(a_frame_count), .err(a_err)
    );

    fold_sequencer #(.NUM_FOLDS(1), .NUM_FOLDS_WIDTH(1), .FRAME_CNT_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst),
        .fin_valid(b_fin_valid), .fin_ready(b_fin_ready),
        .fold_valid(b_fold_valid), .fold_ready(b_fold_ready),
        .fold_counter(b_fold_counter), .done(b_done),
        .res_valid(b_res_valid), .busy(b_busy),
        .frame_count(b_frame_count), .err(b_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a4();
        qa.push_back('{cnt: 2'd0, done: 1'b0});
        qa.push_back('{cnt: 2'd1, done: 1'b0});
        qa.push_back('{cnt: 2'd2, done: 1'b0});
        qa.push_back('{cnt: 2'd3, done: 1'b1});
    endtask

    task automatic res_a(input logic [1:0] fc);
        a_res_valid = 1'b1;
        tick();
        a_res_valid = 1'b0;
        chk("a_res_fin_ready", a_fin_ready, 1);
        chk("a_res_busy", a_busy, 0);
        chk("a_res_frame_count", a_frame_count, fc);
        chk("a_res_err", a_err, 0);
    endtask

    // Monitor: every presented beat is popped and compared.
    always @(negedge clk) begin : mon
        beat_t e;
        if (a_fold_valid === 1'b1) begin
            if (qa.size() == 0) begin
                total++; bad++;
                $display("FAIL a_beat_unexpected: got counter %0d want no beat", a_fold_counter);
            end else begin
                e = qa.pop_front();
                chk("a_beat_counter", a_fold_counter, e.cnt);
                chk("a_beat_done", a_done, e.done);
            end
        end else begin
            chk("a_idle_counter", a_fold_counter, 0);
        end
        if (b_fold_valid === 1'b1) begin
            if (qb.size() == 0) begin
                total++; bad++;
                $display("FAIL b_beat_unexpected: got counter %0d want no beat", b_fold_counter);
            end else begin
                e = qb.pop_front();
                chk("b_beat_counter", b_fold_counter, e.cnt);
                chk("b_beat_done", b_done, e.done);
            end
        end
    end

    initial begin
        logic [6:0] pat;
        rst = 1'b0;
        a_fin_valid = 1'b0; a_fold_ready = 1'b0; a_res_valid = 1'b0;
        b_fin_valid = 1'b0; b_fold_ready = 1'b1; b_res_valid = 1'b0;
        tick();
        tick();
        chk("rst_fin_ready", a_fin_ready, 1);
        chk("rst_fold_valid", a_fold_valid, 0);
        chk("rst_fold_counter", a_fold_counter, 0);
        chk("rst_done", a_done, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_err", a_err, 0);
        chk("rst_frame_count", a_frame_count, 0);
        chk("rst_b_fin_ready", b_fin_ready, 1);

        // Four beats back to back, frame offered in the first cycle out of reset
        rst = 1'b1;
        a_fin_valid = 1'b1;
        a_fold_ready = 1'b1;
        push_a4();
        tick();
        a_fin_valid = 1'b0;
        chk("f1_latency_valid", a_fold_valid, 1);
        chk("f1_first_counter", a_fold_counter, 0);
        chk("f1_busy", a_busy, 1);
        chk("f1_fin_ready", a_fin_ready, 0);
        repeat (3) tick();
        chk("f1_done_last", a_done, 1);
        tick();
        chk("f1_wait_valid", a_fold_valid, 0);
        chk("f1_wait_busy", a_busy, 1);
        chk("f1_wait_done", a_done, 0);
        a_fin_valid = 1'b1;
        tick();
        a_fin_valid = 1'b0;
        chk("f1_wait_ignores_fin", a_fin_ready, 0);
        chk("f1_wait_no_beat", a_fold_valid, 0);
        res_a(2'd1);

        // Stall at fold 2 for three cycles
        qa.push_back('{cnt: 2'd0, done: 1'b0});
        qa.push_back('{cnt: 2'd1, done: 1'b0});
        repeat (4) qa.push_back('{cnt: 2'd2, done: 1'b0});
        qa.push_back('{cnt: 2'd3, done: 1'b1});
        pat = 7'b1100011;
        a_fin_valid = 1'b1;
        tick();
        a_fin_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            a_fold_ready = pat[i];
            tick();
            if (i == 3) begin
                chk("f2_stall_valid", a_fold_valid, 1);
                chk("f2_stall_counter", a_fold_counter, 2);
            end
        end
        a_fold_ready = 1'b1;
        chk("f2_wait_valid", a_fold_valid, 0);
        chk("f2_wait_busy", a_busy, 1);
        res_a(2'd2);

        // fin_valid held through WAIT: re-accepted the cycle after res_valid
        a_fin_valid = 1'b1;
        push_a4();
        tick();
        repeat (4) tick();
        tick();
        chk("f3_wait_fin_ready", a_fin_ready, 0);
        chk("f3_wait_valid", a_fold_valid, 0);
        a_res_valid = 1'b1;
        tick();
        a_res_valid = 1'b0;
        chk("f3_w1_fin_ready", a_fin_ready, 1);
        chk("f3_w1_valid", a_fold_valid, 0);
        chk("f3_frame_count", a_frame_count, 3);
        push_a4();
        tick();
        a_fin_valid = 1'b0;
        chk("f4_w2_valid", a_fold_valid, 1);
        chk("f4_w2_counter", a_fold_counter, 0);
        repeat (4) tick();
        chk("f4_wait_busy", a_busy, 1);
        res_a(2'd0);

        push_a4();
        a_fin_valid = 1'b1;
        tick();
        a_fin_valid = 1'b0;
        repeat (4) tick();
        res_a(2'd1);

        // Stray result pulse in IDLE, then a one-cycle reset
        a_res_valid = 1'b1;
        tick();
        a_res_valid = 1'b0;
        chk("stray_err", a_err, 1);
        chk("stray_frame_count", a_frame_count, 1);
        chk("stray_fin_ready", a_fin_ready, 1);
        chk("stray_busy", a_busy, 0);
        tick();
        chk("stray_err_sticky", a_err, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("post_rst_err", a_err, 0);
        chk("post_rst_frame_count", a_frame_count, 0);

        // Reset mid-frame abandons it cleanly
        qa.push_back('{cnt: 2'd0, done: 1'b0});
        qa.push_back('{cnt: 2'd1, done: 1'b0});
        a_fin_valid = 1'b1;
        tick();
        a_fin_valid = 1'b0;
        tick();
        chk("mid_counter", a_fold_counter, 1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("mid_rst_valid", a_fold_valid, 0);
        chk("mid_rst_busy", a_busy, 0);
        chk("mid_rst_fin_ready", a_fin_ready, 1);
        chk("mid_rst_frame_count", a_frame_count, 0);
        chk("mid_rst_err", a_err, 0);

        // Unfolded instance: five single-beat frames
        for (int k = 1; k <= 5; k++) begin
            qb.push_back('{cnt: 2'd0, done: 1'b1});
            b_fin_valid = 1'b1;
            tick();
            b_fin_valid = 1'b0;
            chk("b_beat_valid", b_fold_valid, 1);
            chk("b_done", b_done, 1);
            tick();
            chk("b_wait_valid", b_fold_valid, 0);
            chk("b_wait_busy", b_busy, 1);
            b_res_valid = 1'b1;
            tick();
            b_res_valid = 1'b0;
            chk("b_frame_count", b_frame_count, k);
        end
        chk("b_err", b_err, 0);

        repeat (2) tick();
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
